// File: rtl/apb_fifo_slave.sv
// APB slave wrapping a 32-bit FIFO: CTRL/STATUS/TXDATA/RXDATA registers, one wait state per transfer.
// Side effects commit only on the RESP->IDLE edge, so a transfer aborted in RESP leaves no trace.
module apb_fifo_slave #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          en, ovf, udf;
    logic [31:0]   mem [0:DEPTH-1];

    logic          access, commit;
    logic [1:0]    sel;
    logic          empty, full;
    logic          ctrl_wr, tx_wr, rx_rd;
    logic          push, pop, clr, ovf_set, udf_set;
    logic [31:0]   status, rd_val;
    logic          unused_addr_bits;

    assign access           = PSEL & PENABLE;
    assign sel              = PADDR[3:2];
    assign unused_addr_bits = ^{PADDR[31:4], PADDR[1:0]};
    assign empty            = (count == '0);
    assign full             = (count == FULL_CNT);
    assign PREADY           = (state == RESP);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        unique case (state)
            IDLE: if (access) state_nxt = RESP;
            RESP: begin
                state_nxt = IDLE;
                commit    = access;
            end
        endcase
    end

    always_comb begin
        ctrl_wr = commit &  PWRITE & (sel == 2'd0);
        tx_wr   = commit &  PWRITE & (sel == 2'd2);
        rx_rd   = commit & ~PWRITE & (sel == 2'd3);
        push    = tx_wr & en & ~full;
        ovf_set = tx_wr & en &  full;
        pop     = rx_rd & ~empty;
        udf_set = rx_rd &  empty;
        clr     = ctrl_wr & PWDATA[1];
    end

    always_comb begin
        status = {19'b0, 9'(count), udf, ovf, full, empty};
        rd_val = '0;
        if (!PWRITE) begin
            unique case (sel)
                2'd0: rd_val = {31'b0, en};
                2'd1: rd_val = status;
                2'd2: rd_val = '0;
                2'd3: rd_val = empty ? '0 : mem[rptr];
            endcase
        end
    end

    // PRDATA is captured entering RESP and falls back to 0 when RESP ends
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) PRDATA <= '0;
        else         PRDATA <= (state == IDLE && access) ? rd_val : '0;
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            en    <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
            irq   <= 1'b0;
        end else begin
            irq <= en & ~empty;
            if (ctrl_wr) en <= PWDATA[0];
            if (clr) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
                ovf   <= 1'b0;
                udf   <= 1'b0;
            end else begin
                if (push) wptr <= wptr + (AW)'(1);
                if (pop)  rptr <= rptr + (AW)'(1);
                if (push)     count <= count + (AW+1)'(1);
                else if (pop) count <= count - (AW+1)'(1);
                if (ovf_set) ovf <= 1'b1;
                if (udf_set) udf <= 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wptr] <= PWDATA;
    end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Bench for apb_fifo_slave: directed vector table, hand sequences for wrap and reset,
// then random transfers against a queue-based reference model.
module tb_apb_fifo_slave;

    localparam int unsigned DEPTH = 8;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;

    apb_fifo_slave #(.DEPTH(DEPTH)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        bit          abort;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vq[$];

    // reference model: FIFO contents as a queue plus the control/sticky bits
    logic [31:0] mq[$];
    bit          m_en, m_ovf, m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input bit ab, input logic [31:0] e, input logic ei);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = d; v.abort = ab; v.exp_rd = e; v.exp_irq = ei;
        vq.push_back(v);
    endtask

    task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input bit abort, output logic [31:0] rdata);
        @(posedge PCLK); #1;
        PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("wait_pready", 32'(PREADY), 32'd0);
        chk("wait_prdata", PRDATA, 32'd0);
        @(posedge PCLK); #1;
        if (abort) PSEL = 1'b0;
        @(negedge PCLK);
        chk("resp_pready", 32'(PREADY), 32'd1);
        rdata = PRDATA;
        @(posedge PCLK); #1;
        chk("done_pready", 32'(PREADY), 32'd0);
        chk("done_prdata", PRDATA, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] addr, input logic wr);
        int n;
        n = mq.size();
        if (wr) return '0;
        case (addr[3:2])
            2'd0:    return 32'(m_en);
            2'd1:    return 32'(n) * 16 + 32'(m_udf) * 8 + 32'(m_ovf) * 4
                            + ((n == DEPTH) ? 32'd2 : 32'd0) + ((n == 0) ? 32'd1 : 32'd0);
            2'd2:    return '0;
            default: return (n == 0) ? 32'd0 : mq[0];
        endcase
    endfunction

    task automatic m_commit(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        if (wr) begin
            if (addr[3:2] == 2'd0) begin
                m_en = wdata[0];
                if (wdata[1]) begin
                    mq.delete();
                    m_ovf = 1'b0;
                    m_udf = 1'b0;
                end
            end else if (addr[3:2] == 2'd2 && m_en) begin
                if (mq.size() == DEPTH) m_ovf = 1'b1;
                else                    mq.push_back(wdata);
            end
        end else if (addr[3:2] == 2'd3) begin
            if (mq.size() != 0) void'(mq.pop_front());
            else                m_udf = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        prev_irq;
        logic [31:0] exp_q[$];
        logic [31:0] d;

        PRESET = 1'b0; PADDR = '0; PWRITE = 1'b0; PENABLE = 1'b0; PSEL = 1'b0; PWDATA = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        PRESET = 1'b1;

        // directed vectors
        add(32'h0000_0000, 1'b1, 32'h1, 1'b0, 32'h0, 1'b0);
        add(32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0);
        for (int i = 1; i <= 8; i++)
            add(32'h0000_0008, 1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, 32'h0, 1'b1);
        add(32'hFFFF_FFF4, 1'b0, 32'h0, 1'b0, 32'h82, 1'b1);
        add(32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        add(32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'h86, 1'b1);
        for (int i = 1; i <= 8; i++)
            add(32'h1230_000C, 1'b0, 32'h0, 1'b0, 32'hA5A5_0000 + 32'(i), (i < 8));
        add(32'h0000_000C, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        add(32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'hD, 1'b0);
        add(32'h0000_0000, 1'b1, 32'h3, 1'b0, 32'h0, 1'b0);
        add(32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0);
        add(32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0);
        add(32'h0000_0000, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        add(32'h0000_0008, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0);
        add(32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0);
        add(32'h0000_0000, 1'b1, 32'h1, 1'b0, 32'h0, 1'b0);
        add(32'h0000_0008, 1'b1, 32'h55, 1'b1, 32'h0, 1'b0);
        add(32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0);

        prev_irq = 1'b0;
        foreach (vq[i]) begin
            apb(vq[i].addr, vq[i].wr, vq[i].wdata, vq[i].abort, rd);
            chk($sformatf("vec%0d_rdata", i), rd, vq[i].exp_rd);
            chk($sformatf("vec%0d_irq_hold", i), 32'(irq), 32'(prev_irq));
            @(posedge PCLK); #1;
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vq[i].exp_irq));
            prev_irq = vq[i].exp_irq;
        end

        // pointer wrap: 5 in/out then 6 in/out crosses the end of an 8-deep buffer
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5 + r; k++) begin
                d = $urandom();
                apb(32'h8, 1'b1, d, 1'b0, rd);
                exp_q.push_back(d);
            end
            for (int k = 0; k < 5 + r; k++) begin
                apb(32'hC, 1'b0, 32'h0, 1'b0, rd);
                chk("wrap_data", rd, exp_q.pop_front());
            end
        end
        apb(32'h4, 1'b0, 32'h0, 1'b0, rd);
        chk("wrap_status", rd, 32'h1);

        // reset asserted during RESP with three entries queued
        for (int k = 0; k < 3; k++) apb(32'h8, 1'b1, 32'hC0DE_0000 + 32'(k), 1'b0, rd);
        @(posedge PCLK); #1;
        PADDR = 32'hC; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        chk("mid_pready", 32'(PREADY), 32'd1);
        chk("mid_prdata", PRDATA, 32'hC0DE_0000);
        chk("mid_irq", 32'(irq), 32'd1);
        #2 PRESET = 1'b0;
        #1;
        chk("arst_pready", 32'(PREADY), 32'd0);
        chk("arst_prdata", PRDATA, 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
        apb(32'h4, 1'b0, 32'h0, 1'b0, rd);
        chk("arst_status", rd, 32'h1);
        apb(32'h0, 1'b0, 32'h0, 1'b0, rd);
        chk("arst_ctrl", rd, 32'h0);

        mq.delete();
        m_en = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // random transfers against the model
        for (int t = 0; t < 400; t++) begin
            int unsigned op;
            logic [1:0]  s;
            logic        w;
            logic [31:0] a, exp;
            bit          ab;
            op = $urandom_range(0, 9);
            d  = $urandom();
            case (op)
                0, 1: begin
                    s = 2'd0; w = 1'b1;
                    d[0] = ($urandom_range(0, 4) != 0);
                    d[1] = ($urandom_range(0, 19) == 0);
                end
                2:       begin s = 2'd0; w = 1'b0; end
                3:       begin s = 2'd1; w = 1'b0; end
                4, 5, 6: begin s = 2'd2; w = 1'b1; end
                7, 8:    begin s = 2'd3; w = 1'b0; end
                default: begin s = 2'($urandom_range(0, 3)); w = 1'($urandom_range(0, 1)); end
            endcase
            if (s == 2'd0 && w && op == 9) d[1] = 1'b0;
            a = ($urandom() & ~32'hC) | {28'b0, s, 2'b00};
            ab = ($urandom_range(0, 7) == 0);
            exp = m_read(a, w);
            apb(a, w, d, ab, rd);
            chk($sformatf("rnd%0d_rdata", t), rd, exp);
            if (!ab) m_commit(a, w, d);
            @(posedge PCLK); #1;
            chk($sformatf("rnd%0d_irq", t), 32'(irq), 32'(m_en && mq.size() != 0));
        end

        apb(32'h4, 1'b0, 32'h0, 1'b0, rd);
        chk("final_status", rd, m_read(32'h4, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
